// File: rtl/riscv_register_file_mp.sv
// Flop-based multi-ported register file with a per-register busy scoreboard.
// Writes are staged one cycle, then committed; staged data can be forwarded to the read ports.
module riscv_register_file_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RPORTS = 3,
    parameter int NUM_WPORTS = 2,
    parameter int FPU        = 0,
    parameter int Zfinx      = 0,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             test_en_i,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_RPORTS-1:0]            rbusy_o,
    input  logic [NUM_WPORTS*ADDR_WIDTH-1:0] waddr_i,
    input  logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_WPORTS-1:0]            we_i,
    input  logic                             rsv_i,
    input  logic [ADDR_WIDTH-1:0]            rsv_addr_i,
    input  logic                             flush_i
);

    localparam int NUM_TOT = (FPU != 0 && Zfinx == 0) ? 64 : 32;
    localparam int IDX_W   = (NUM_TOT == 64) ? 6 : 5;

    logic [DATA_WIDTH-1:0] mem_q   [NUM_TOT];
    logic [NUM_TOT-1:0]    busy_q;
    logic [NUM_TOT-1:0]    busy_d;
    logic [NUM_WPORTS-1:0] we_q;
    logic [NUM_WPORTS-1:0] we_d;
    logic [ADDR_WIDTH-1:0] waddr_q [NUM_WPORTS];
    logic [DATA_WIDTH-1:0] wdata_q [NUM_WPORTS];

    // Scan enable has no role in a flop-based array.
    logic unused_test_en;
    assign unused_test_en = test_en_i;

    // Nonzero and inside the implemented bank; x0 and the missing FP bank never store or go busy.
    function automatic logic addr_live(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && (32'(a) < 32'(NUM_TOT));
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    always_comb begin
        we_d = '0;
        for (int p = 0; p < NUM_WPORTS; p++) begin
            we_d[p] = we_i[p] && addr_live(waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

    // Reserve is applied last so it beats both a same-cycle write clear and a flush.
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            for (int p = 0; p < NUM_WPORTS; p++) begin
                if (we_d[p]) begin
                    busy_d[idx(waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH])] = 1'b0;
                end
            end
        end
        if (rsv_i && addr_live(rsv_addr_i)) begin
            busy_d[idx(rsv_addr_i)] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= '0;
            busy_q <= '0;
            for (int p = 0; p < NUM_WPORTS; p++) begin
                waddr_q[p] <= '0;
                wdata_q[p] <= '0;
            end
            for (int i = 0; i < NUM_TOT; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            we_q   <= we_d;
            busy_q <= busy_d;
            for (int p = 0; p < NUM_WPORTS; p++) begin
                if (we_i[p]) begin
                    waddr_q[p] <= waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_q[p] <= wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            // Later ports overwrite earlier ones, so the highest index wins a conflict.
            for (int p = 0; p < NUM_WPORTS; p++) begin
                if (we_q[p]) begin
                    mem_q[idx(waddr_q[p])] <= wdata_q[p];
                end
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        for (int r = 0; r < NUM_RPORTS; r++) begin
            logic [ADDR_WIDTH-1:0] ra;
            logic [DATA_WIDTH-1:0] rd;
            ra = raddr_i[r*ADDR_WIDTH +: ADDR_WIDTH];
            rd = mem_q[idx(ra)];
            if (BYPASS != 0) begin
                for (int w = 0; w < NUM_WPORTS; w++) begin
                    if (we_q[w] && (waddr_q[w] == ra)) begin
                        rd = wdata_q[w];
                    end
                end
            end
            if (!addr_live(ra)) begin
                rd = '0;
            end
            rdata_o[r*DATA_WIDTH +: DATA_WIDTH] = rd;
            rbusy_o[r] = addr_live(ra) && busy_q[idx(ra)];
        end
    end

endmodule

// File: tb/tb_riscv_register_file_mp.sv
// Bench for riscv_register_file_mp: an integer-only bypassing instance (A) and an
// FP-bank instance without bypass (B), checked through an expected-value queue.
module tb_riscv_register_file_mp;

  logic clk;
  logic rst_n;
  logic test_en;

  logic [14:0] a_raddr;
  logic [95:0] a_rdata;
  logic [2:0]  a_rbusy;
  logic [9:0]  a_waddr;
  logic [63:0] a_wdata;
  logic [1:0]  a_we;
  logic        a_rsv;
  logic [4:0]  a_rsv_addr;
  logic        a_flush;

  logic [17:0] b_raddr;
  logic [95:0] b_rdata;
  logic [2:0]  b_rbusy;
  logic [11:0] b_waddr;
  logic [63:0] b_wdata;
  logic [1:0]  b_we;
  logic        b_rsv;
  logic [5:0]  b_rsv_addr;
  logic        b_flush;

  riscv_register_file_mp u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .test_en_i  (test_en),
    .raddr_i    (a_raddr),
    .rdata_o    (a_rdata),
    .rbusy_o    (a_rbusy),
    .waddr_i    (a_waddr),
    .wdata_i    (a_wdata),
    .we_i       (a_we),
    .rsv_i      (a_rsv),
    .rsv_addr_i (a_rsv_addr),
    .flush_i    (a_flush)
  );

  riscv_register_file_mp #(
    .ADDR_WIDTH (6),
    .FPU        (1),
    .BYPASS     (0)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .test_en_i  (test_en),
    .raddr_i    (b_raddr),
    .rdata_o    (b_rdata),
    .rbusy_o    (b_rbusy),
    .waddr_i    (b_waddr),
    .wdata_i    (b_wdata),
    .we_i       (b_we),
    .rsv_i      (b_rsv),
    .rsv_addr_i (b_rsv_addr),
    .flush_i    (b_flush)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  // entry: {inst[35], port[34:33], kind[32] (0=data,1=busy), value[31:0]}
  logic [35:0] exp_q[$];
  string       name_q[$];
  int          errors;
  int          checks;
  logic [35:0] mon_ent;
  logic [31:0] mon_act;
  string       mon_nm;
  int          mon_port;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_ent  = exp_q.pop_front();
      mon_nm   = name_q.pop_front();
      mon_port = int'(mon_ent[34:33]);
      if (!mon_ent[35]) mon_act = mon_ent[32] ? {31'b0, a_rbusy[mon_port]} : a_rdata[mon_port*32 +: 32];
      else              mon_act = mon_ent[32] ? {31'b0, b_rbusy[mon_port]} : b_rdata[mon_port*32 +: 32];
      checks++;
      if (mon_act !== mon_ent[31:0]) begin
        errors++;
        $display("FAIL %s: inst=%0d port=%0d got 0x%08h expected 0x%08h",
                 mon_nm, mon_ent[35], mon_port, mon_act, mon_ent[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    a_we = '0; b_we = '0;
    a_rsv = 1'b0; b_rsv = 1'b0;
    a_flush = 1'b0; b_flush = 1'b0;
  endtask

  task automatic wr(input bit inst, input int port, input logic [5:0] addr, input logic [31:0] data);
    if (!inst) begin
      a_we[port] = 1'b1;
      a_waddr[port*5 +: 5] = addr[4:0];
      a_wdata[port*32 +: 32] = data;
    end else begin
      b_we[port] = 1'b1;
      b_waddr[port*6 +: 6] = addr;
      b_wdata[port*32 +: 32] = data;
    end
  endtask

  task automatic rd(input bit inst, input int port, input logic [5:0] addr);
    if (!inst) a_raddr[port*5 +: 5] = addr[4:0];
    else       b_raddr[port*6 +: 6] = addr;
  endtask

  task automatic exp_data(input bit inst, input int port, input logic [31:0] v, input string nm);
    exp_q.push_back({inst, 2'(port), 1'b0, v});
    name_q.push_back(nm);
  endtask

  task automatic exp_busy(input bit inst, input int port, input logic v, input string nm);
    exp_q.push_back({inst, 2'(port), 1'b1, {31'b0, v}});
    name_q.push_back(nm);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; test_en = 1'b0;
    a_raddr = '0; a_waddr = '0; a_wdata = '0; a_we = '0; a_rsv = 1'b0; a_rsv_addr = '0; a_flush = 1'b0;
    b_raddr = '0; b_waddr = '0; b_wdata = '0; b_we = '0; b_rsv = 1'b0; b_rsv_addr = '0; b_flush = 1'b0;

    next_cycle();
    rd(0, 0, 6'd5); rd(0, 1, 6'd31);
    exp_data(0, 0, 32'h0, "in_reset_rdata"); exp_busy(0, 1, 1'b0, "in_reset_rbusy");
    next_cycle();
    rst_n = 1'b1;

    // all addresses read 0 / not busy after reset
    for (int a = 0; a < 32; a++) begin
      next_cycle();
      for (int p = 0; p < 3; p++) begin
        rd(0, p, 6'((a + p * 11) % 32));
        rd(1, p, 6'((a * 2 + p) % 64));
        exp_data(0, p, 32'h0, "reset_rdata"); exp_busy(0, p, 1'b0, "reset_rbusy");
        exp_data(1, p, 32'h0, "reset_rdata_fp"); exp_busy(1, p, 1'b0, "reset_rbusy_fp");
      end
    end

    // x0 stays zero
    next_cycle();
    wr(0, 0, 6'd0, 32'hDEADBEEF); wr(1, 0, 6'd0, 32'hDEADBEEF);
    rd(0, 0, 6'd0); rd(1, 0, 6'd0);
    exp_data(0, 0, 32'h0, "x0_t"); exp_data(1, 0, 32'h0, "x0_t_fp");
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      exp_data(0, 0, 32'h0, "x0_after"); exp_data(1, 0, 32'h0, "x0_after_fp");
    end

    // write latency with and without bypass
    next_cycle();
    wr(0, 0, 6'd5, 32'h12345678); wr(1, 0, 6'd5, 32'h12345678);
    rd(0, 2, 6'd5); rd(1, 2, 6'd5);
    exp_data(0, 2, 32'h0, "lat_t_byp"); exp_data(1, 2, 32'h0, "lat_t_nobyp");
    next_cycle();
    exp_data(0, 2, 32'h12345678, "lat_t1_byp"); exp_data(1, 2, 32'h0, "lat_t1_nobyp");
    next_cycle();
    exp_data(0, 2, 32'h12345678, "lat_t2_byp"); exp_data(1, 2, 32'h12345678, "lat_t2_nobyp");

    // same-cycle conflict on x7: port 1 wins
    next_cycle();
    wr(0, 0, 6'd7, 32'hAAAA0000); wr(0, 1, 6'd7, 32'h5555FFFF);
    wr(1, 0, 6'd7, 32'hAAAA0000); wr(1, 1, 6'd7, 32'h5555FFFF);
    rd(0, 0, 6'd7); rd(1, 0, 6'd7);
    exp_data(0, 0, 32'h0, "conflict_t"); exp_data(1, 0, 32'h0, "conflict_t_fp");
    next_cycle();
    exp_data(0, 0, 32'h5555FFFF, "conflict_byp"); exp_data(1, 0, 32'h0, "conflict_t1_fp");
    next_cycle();
    rd(0, 1, 6'd7);
    exp_data(0, 0, 32'h5555FFFF, "conflict_mem"); exp_data(0, 1, 32'h5555FFFF, "conflict_mem_p1");
    exp_data(1, 0, 32'h5555FFFF, "conflict_mem_fp");

    // back-to-back writes to x8
    next_cycle();
    wr(0, 0, 6'd8, 32'h11111111);
    rd(0, 0, 6'd8);
    next_cycle();
    wr(0, 1, 6'd8, 32'h22222222);
    exp_data(0, 0, 32'h11111111, "b2b_t1");
    next_cycle();
    exp_data(0, 0, 32'h22222222, "b2b_t2");
    next_cycle();
    exp_data(0, 0, 32'h22222222, "b2b_t3");

    // scoreboard on x9
    next_cycle();
    a_rsv = 1'b1; a_rsv_addr = 5'd9;
    rd(0, 1, 6'd9);
    exp_busy(0, 1, 1'b0, "busy_t");
    next_cycle();
    exp_busy(0, 1, 1'b1, "busy_t1");
    next_cycle();
    exp_busy(0, 1, 1'b1, "busy_t2");
    next_cycle();
    a_rsv = 1'b1; a_rsv_addr = 5'd9; wr(0, 0, 6'd9, 32'h00000099);
    exp_busy(0, 1, 1'b1, "busy_t3");
    next_cycle();
    exp_busy(0, 1, 1'b1, "busy_set_wins");
    next_cycle();
    wr(0, 0, 6'd9, 32'h0000009A);
    exp_busy(0, 1, 1'b1, "busy_t5");
    next_cycle();
    exp_busy(0, 1, 1'b0, "busy_cleared");
    exp_data(0, 1, 32'h0000009A, "busy_wdata");

    // FP bank on instance B
    next_cycle();
    wr(1, 0, 6'd32, 32'h3F800000); wr(1, 1, 6'd1, 32'h00000001);
    rd(1, 0, 6'd32); rd(1, 1, 6'd1); rd(1, 2, 6'd0);
    next_cycle();
    exp_data(1, 0, 32'h0, "fp_t1_f0"); exp_data(1, 1, 32'h0, "fp_t1_x1");
    next_cycle();
    b_rsv = 1'b1; b_rsv_addr = 6'd32;
    exp_data(1, 0, 32'h3F800000, "fp_f0"); exp_data(1, 1, 32'h00000001, "fp_x1");
    exp_data(1, 2, 32'h0, "fp_x0");
    next_cycle();
    b_rsv = 1'b1; b_rsv_addr = 6'd0;
    exp_busy(1, 0, 1'b1, "fp_f0_busy");
    next_cycle();
    exp_busy(1, 2, 1'b0, "fp_x0_never_busy");

    // reset with a write staged
    next_cycle();
    wr(0, 0, 6'd3, 32'hCAFEF00D);
    a_rsv = 1'b1; a_rsv_addr = 5'd4;
    next_cycle();
    rst_n = 1'b0;
    rd(0, 0, 6'd3); rd(0, 1, 6'd5); rd(0, 2, 6'd4);
    exp_data(0, 1, 32'h0, "async_rst_mem");
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    exp_data(0, 0, 32'h0, "rst_staged_x3"); exp_busy(0, 0, 1'b0, "rst_busy_x3");
    exp_data(0, 1, 32'h0, "rst_x5"); exp_busy(0, 2, 1'b0, "rst_busy_x4");

    // flush with four reserved registers, plus a reserve alongside the flush
    for (int r = 10; r < 14; r++) begin
      next_cycle();
      a_rsv = 1'b1; a_rsv_addr = 5'(r);
    end
    next_cycle();
    a_flush = 1'b1; a_rsv = 1'b1; a_rsv_addr = 5'd14;
    rd(0, 0, 6'd10); rd(0, 1, 6'd11); rd(0, 2, 6'd13);
    exp_busy(0, 0, 1'b1, "pre_flush_x10"); exp_busy(0, 1, 1'b1, "pre_flush_x11");
    exp_busy(0, 2, 1'b1, "pre_flush_x13");
    next_cycle();
    rd(0, 2, 6'd14);
    exp_busy(0, 0, 1'b0, "flush_x10"); exp_busy(0, 1, 1'b0, "flush_x11");
    exp_busy(0, 2, 1'b1, "flush_rsv_wins");
    next_cycle();
    rd(0, 0, 6'd12); rd(0, 1, 6'd13); rd(0, 2, 6'd0);
    exp_busy(0, 0, 1'b0, "flush_x12"); exp_busy(0, 1, 1'b0, "flush_x13");
    exp_busy(0, 2, 1'b0, "flush_x0");

    // ---------------- final report ----------------
    next_cycle();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
